// File: rtl/cook_pkg.sv
// cook_pkg: shared encodings and constants for the microwave cook sequencer.
// Ports: none (package). Imported by cook_ctrl and tick_prescaler.
package cook_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_COOK  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [3:0]  BCD_MAX      = 4'd9;
  localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
  localparam logic [15:0] QUICK_TIME   = 16'h0030;

  // A cook time is startable when the door is shut, the time is
  // non-zero and the seconds-tens digit is a legal 0..5.
  function automatic logic start_ok(
    input logic [15:0] t,
    input logic        door
  );
    return door && (t != 16'h0) && (t[7:4] <= SEC_TENS_MAX);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk to a one-cycle count tick every TICK_DIV runs.
// Ports: clk, rst_n (async low), clr_i (sync clear), run_i (advance), tick_o.
module tick_prescaler
  import cook_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = run_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cook_ctrl.sv
// cook_ctrl: microwave cook sequencer (keypad entry, load, cook, pause, done).
// Ports: clk, clrn, key/start/stop/clear strobes, door_closed, timer_zero in;
//        load_data, loadn, count_en, mag_on, done, state out.
// Option: define QUICK_START_EN for a 30 s quick cook on start from IDLE.
module cook_ctrl
  import cook_pkg::*;
#(
  parameter int TICK_DIV  = 100,
  parameter int DONE_SECS = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        door_closed,
  input  logic        timer_zero,
  output logic [15:0] load_data,
  output logic        loadn,
  output logic        count_en,
  output logic        mag_on,
  output logic        done,
  output logic [2:0]  state
);

  localparam int DW = $clog2(DONE_SECS + 1);
  localparam logic [DW-1:0] DLAST = DW'(DONE_SECS - 1);

  state_e        state_q, state_d;
  logic [15:0]   entry_q, entry_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          loadn_q, mag_q, done_q;

  logic key_ok;
  logic tick;
  logic pre_clr;
  logic pre_run;
  logic cook_run;

  assign key_ok = key_valid && (key_digit <= BCD_MAX);

  // Keep counting in COOK unless leaving for PAUSE; the prescaler
  // then resumes from the held phase.
  assign cook_run = (state_q == S_COOK) &&
                    (timer_zero || (door_closed && !stop));
  assign pre_run  = cook_run || (state_q == S_DONE);
  assign pre_clr  = (state_q == S_LOAD);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_pre (
    .clk    (clk),
    .rst_n  (clrn),
    .clr_i  (pre_clr),
    .run_i  (pre_run),
    .tick_o (tick)
  );

  // No decrement once the chain reads zero or when cooking is abandoned.
  assign count_en = (state_q == S_LOAD) ||
                    ((state_q == S_COOK) && tick &&
                     !timer_zero && !clear);

  assign load_data = entry_q;
  assign loadn     = loadn_q;
  assign mag_on    = mag_q;
  assign done      = done_q;
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          entry_d = '0;
        end else if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
`ifdef QUICK_START_EN
          if (door_closed) begin
            entry_d = QUICK_TIME;
            state_d = S_LOAD;
          end
`else
          state_d = S_IDLE;
`endif
        end else if (key_ok) begin
          entry_d = {entry_q[11:0], key_digit};
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (clear) begin
          entry_d = '0;
          state_d = S_IDLE;
        end else if (stop) begin
          state_d = S_ENTRY;
        end else if (start) begin
          if (start_ok(entry_q, door_closed)) begin
            state_d = S_LOAD;
          end
        end else if (key_ok) begin
          entry_d = {entry_q[11:0], key_digit};
        end
      end
      S_LOAD: begin
        state_d = S_COOK;
      end
      S_COOK: begin
        if (clear) begin
          entry_d = '0;
          state_d = S_IDLE;
        end else if (timer_zero) begin
          dcnt_d  = '0;
          state_d = S_DONE;
        end else if (!door_closed || stop) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (clear || stop) begin
          entry_d = '0;
          state_d = S_IDLE;
        end else if (start && door_closed) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        if (clear || stop || start || key_valid) begin
          entry_d = '0;
          state_d = S_IDLE;
        end else if (tick) begin
          if (dcnt_q == DLAST) begin
            entry_d = '0;
            state_d = S_IDLE;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      dcnt_q  <= '0;
      loadn_q <= 1'b1;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      dcnt_q  <= dcnt_d;
      loadn_q <= (state_d != S_LOAD);
      mag_q   <= (state_d == S_COOK);
      done_q  <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_cook_ctrl.sv
// tb_cook_ctrl: scoreboard bench for cook_ctrl with a BCD timer-chain model.
// Expected state transitions are queued by stimulus and popped by a monitor.
module tb_cook_ctrl;

  localparam int TD = 4;
  localparam int DS = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ENTRY = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_COOK  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        door_closed = 1'b1;
  logic        timer_zero;
  logic [15:0] load_data;
  logic        loadn;
  logic        count_en;
  logic        mag_on;
  logic        done;
  logic [2:0]  state;

  logic [15:0] tm = 16'h0;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] ld;
    logic        mag;
    logic        dn;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic [2:0] prev_st = 3'd0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cook_ctrl #(
    .TICK_DIV  (TD),
    .DONE_SECS (DS)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .door_closed (door_closed),
    .timer_zero  (timer_zero),
    .load_data   (load_data),
    .loadn       (loadn),
    .count_en    (count_en),
    .mag_on      (mag_on),
    .done        (done),
    .state       (state)
  );

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 0) so = so - 1;
    else begin
      so = 4'd9;
      if (st != 0) st = st - 1;
      else begin
        st = 4'd5;
        if (mo != 0) mo = mo - 1;
        else begin
          mo = 4'd9;
          mt = mt - 1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  always @(posedge clk) begin
    if (!loadn) tm <= load_data;
    else if (count_en) tm <= bcd_dec(tm);
  end

  assign timer_zero = (tm == 16'h0);

  always @(negedge clk) begin
    if (state !== prev_st) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL trans_unexpected got st=%0d ld=%h want none",
                 state, load_data);
      end else begin
        e = exp_q.pop_front();
        if ({state, load_data, mag_on, done} !== e) begin
          bad++;
          $display("FAIL trans got st=%0d ld=%h mag=%b dn=%b want st=%0d ld=%h mag=%b dn=%b",
                   state, load_data, mag_on, done, e.st, e.ld, e.mag, e.dn);
        end
      end
      prev_st = state;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] s, input logic [15:0] l,
                      input logic m, input logic d);
    exp_q.push_back({s, l, m, d});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    key_digit = d;
    key_valid = 1'b1;
    cyc(1);
    key_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic wait_tick(input string nm);
    int k;
    k = 0;
    do begin
      cyc(1);
      k++;
    end while (!count_en && k < 50);
    chk(nm, count_en, 1);
  endtask

  task automatic wait_st(input logic [2:0] s, input int maxc,
                         input string nm);
    int k;
    k = 0;
    while (state !== s && k < maxc) begin
      cyc(1);
      k++;
    end
    chk(nm, state, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int ticks, doncyc, lowl, ierr, prev, c, cen, magc, off;

    #12;
    chk("rst_state", state, ST_IDLE);
    chk("rst_ld", load_data, 16'h0000);
    chk("rst_loadn", loadn, 1);
    chk("rst_cen", count_en, 0);
    chk("rst_mag", mag_on, 0);
    chk("rst_done", done, 0);
    clrn = 1'b1;
    cyc(1);

    // full cook of 01:25
    push(ST_ENTRY, 16'h0001, 0, 0);
    key(4'd1);
    key(4'd2);
    key(4'd5);
    chk("t1_ld", load_data, 16'h0125);
    push(ST_LOAD, 16'h0125, 0, 0);
    push(ST_COOK, 16'h0125, 1, 0);
    push(ST_DONE, 16'h0125, 0, 1);
    push(ST_IDLE, 16'h0000, 0, 0);
    do_start();
    chk("t1_load_loadn", loadn, 0);
    chk("t1_load_cen", count_en, 1);
    ticks = 0; doncyc = 0; lowl = 0; ierr = 0; prev = 0; c = 0;
    for (int k = 0; k < 1000 && state !== ST_IDLE; k++) begin
      cyc(1);
      c++;
      if (count_en) begin
        ticks++;
        if (c - prev != TD) ierr++;
        prev = c;
      end
      if (done) doncyc++;
      if (!loadn) lowl++;
    end
    chk("t1_ticks", ticks, 85);
    chk("t1_tick_period", ierr, 0);
    chk("t1_done_cycles", doncyc, 11);
    chk("t1_loadn_extra", lowl, 0);
    chk("t1_idle", state, ST_IDLE);

    // pause with door open, resume without reload
    push(ST_ENTRY, 16'h0000, 0, 0);
    key(4'd0);
    key(4'd5);
    chk("t2_ld", load_data, 16'h0005);
    push(ST_LOAD, 16'h0005, 0, 0);
    push(ST_COOK, 16'h0005, 1, 0);
    do_start();
    wait_tick("t2_tick1");
    wait_tick("t2_tick2");
    push(ST_PAUSE, 16'h0005, 0, 0);
    cyc(2);
    door_closed = 1'b0;
    cyc(1);
    cen = 0; magc = 0;
    for (int k = 0; k < 10; k++) begin
      if (count_en) cen++;
      if (mag_on) magc++;
      cyc(1);
    end
    chk("t2_pause_st", state, ST_PAUSE);
    chk("t2_pause_cen", cen, 0);
    chk("t2_pause_mag", magc, 0);
    chk("t2_timer_held", tm, 16'h0003);
    door_closed = 1'b1;
    cyc(1);
    push(ST_COOK, 16'h0005, 1, 0);
    do_start();
    off = -1; lowl = 0;
    for (int k = 0; k < 20; k++) begin
      if (count_en) begin
        off = k;
        break;
      end
      if (!loadn) lowl++;
      cyc(1);
    end
    chk("t2_resume_off", off, 2);
    chk("t2_resume_loadn", lowl, 0);
    push(ST_DONE, 16'h0005, 0, 1);
    push(ST_IDLE, 16'h0000, 0, 0);
    wait_st(ST_IDLE, 200, "t2_idle");

    // illegal seconds-tens rejects start
    push(ST_ENTRY, 16'h0001, 0, 0);
    key(4'd1);
    key(4'd7);
    key(4'd0);
    chk("t3_ld", load_data, 16'h0170);
    do_start();
    chk("t3_start_ign", state, ST_ENTRY);
    push(ST_IDLE, 16'h0000, 0, 0);
    do_clear();
    chk("t3_clr_ld", load_data, 16'h0000);
    chk("t3_clr_st", state, ST_IDLE);

    // shift-out of oldest digit, bad digit, door-open start
    push(ST_ENTRY, 16'h0009, 0, 0);
    key(4'd9);
    key(4'd9);
    key(4'd9);
    key(4'd9);
    key(4'd1);
    chk("t4_ld", load_data, 16'h9991);
    key(4'hA);
    chk("t4_bad_digit", load_data, 16'h9991);
    door_closed = 1'b0;
    do_start();
    chk("t4_door_start", state, ST_ENTRY);
    push(ST_IDLE, 16'h0000, 0, 0);
    do_clear();
    door_closed = 1'b1;

    // clear beats door open in COOK
    push(ST_ENTRY, 16'h0005, 0, 0);
    key(4'd5);
    push(ST_LOAD, 16'h0005, 0, 0);
    push(ST_COOK, 16'h0005, 1, 0);
    do_start();
    cyc(2);
    push(ST_IDLE, 16'h0000, 0, 0);
    clear = 1'b1;
    door_closed = 1'b0;
    cyc(1);
    clear = 1'b0;
    chk("t5_clr_st", state, ST_IDLE);
    chk("t5_clr_ld", load_data, 16'h0000);
    door_closed = 1'b1;
    cyc(1);

    // timer_zero beats stop; key exits DONE early
    push(ST_ENTRY, 16'h0001, 0, 0);
    key(4'd1);
    push(ST_LOAD, 16'h0001, 0, 0);
    push(ST_COOK, 16'h0001, 1, 0);
    do_start();
    wait_tick("t5_tick");
    cyc(1);
    push(ST_DONE, 16'h0001, 0, 1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("t5_zero_stop", state, ST_DONE);
    chk("t5_done", done, 1);
    cyc(2);
    push(ST_IDLE, 16'h0000, 0, 0);
    key(4'd7);
    chk("t5_early_st", state, ST_IDLE);
    chk("t5_early_ld", load_data, 16'h0000);

    // async reset mid-cook
    push(ST_ENTRY, 16'h0002, 0, 0);
    key(4'd2);
    push(ST_LOAD, 16'h0002, 0, 0);
    push(ST_COOK, 16'h0002, 1, 0);
    do_start();
    cyc(3);
    push(ST_IDLE, 16'h0000, 0, 0);
    #2;
    clrn = 1'b0;
    #1;
    chk("t6_rst_st", state, ST_IDLE);
    chk("t6_rst_ld", load_data, 16'h0000);
    chk("t6_rst_loadn", loadn, 1);
    chk("t6_rst_cen", count_en, 0);
    chk("t6_rst_mag", mag_on, 0);
    chk("t6_rst_done", done, 0);
    cyc(1);
    clrn = 1'b1;
    cyc(1);

    // start from IDLE
`ifdef QUICK_START_EN
    push(ST_LOAD, 16'h0030, 0, 0);
    push(ST_COOK, 16'h0030, 1, 0);
    do_start();
    chk("t7_qs_st", state, ST_LOAD);
    chk("t7_qs_ld", load_data, 16'h0030);
    cyc(1);
    chk("t7_qs_cook", state, ST_COOK);
    push(ST_IDLE, 16'h0000, 0, 0);
    do_clear();
    chk("t7_qs_clr", state, ST_IDLE);
`else
    do_start();
    chk("t7_idle_start_st", state, ST_IDLE);
    chk("t7_idle_start_ld", load_data, 16'h0000);
    cyc(2);
    chk("t7_idle_start_hold", state, ST_IDLE);
`endif

    cyc(3);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cook_ctrl.md
Name: cook_ctrl

Overview:
Microwave cook sequencer. Collects keypad digits into an MM:SS entry register and drives the countdown timer chain's load, enable and data. Generates the 1 s count tick and gates the magnetron on door/stop/start/clear events. Sits between keypad/door inputs and the digit-counter chain (min tens/ones, sec tens (mod6), sec ones); uses the chain's all-zero flag to detect end of cook.

Parameters:
TICK_DIV, 100, clk cycles per 1 s count tick (>=2)
DONE_SECS, 3, number of ticks the done indication is held before returning to IDLE

Ports:
clk  in  1  system clock, rising edge
clrn  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe, key_digit valid
key_digit  in  4  BCD digit 0-9; values >9 ignored
start  in  1  one-cycle strobe
stop  in  1  one-cycle strobe
clear  in  1  one-cycle strobe
door_closed  in  1  level, 1 = door closed
timer_zero  in  1  from timer chain: all digits zero
load_data  out  16  {min_tens, min_ones, sec_tens, sec_ones} BCD to timer chain
loadn  out  1  active-low load to timer chain
count_en  out  1  timer chain enable (decrement one step when high)
mag_on  out  1  magnetron drive
done  out  1  cook complete indication
state  out  3  current FSM state encoding

Behaviour:
- Reset (clrn=0, async): state=IDLE, entry register=0000, prescaler=0, loadn=1, count_en=0, mag_on=0, done=0. Reset mid-cook forces all of this immediately.
- load_data is the entry register, continuously driven.
- Event priority per cycle: clear > door open > stop > start > key_valid.
- IDLE (0): key_valid with digit<=9 -> entry = {entry[11:0], digit}, go ENTRY.
- ENTRY (1): key_valid shifts digit in (oldest digit falls out of min_tens). clear -> entry=0000, IDLE. start accepted only if door_closed=1, entry!=0000 and sec_tens<=5 -> LOAD; otherwise ignored, state unchanged.
- LOAD (2): exactly one cycle; loadn=0, count_en=1 (timer loads on this edge); prescaler cleared -> COOK.
- COOK (3): mag_on=1. Prescaler counts 0..TICK_DIV-1; at TICK_DIV-1, count_en=1 for that single cycle and prescaler wraps to 0. First tick is TICK_DIV cycles after entering COOK. timer_zero=1 -> DONE (takes precedence over a simultaneous door open/stop; clear still wins -> IDLE). Door open or stop -> PAUSE; prescaler holds its value. clear -> IDLE, entry=0000.
- PAUSE (4): mag_on=0, count_en=0, prescaler frozen. start with door_closed -> COOK; prescaler resumes from its held value; timer is not reloaded. Start with door open is ignored. stop or clear -> IDLE, entry=0000.
- DONE (5): done=1, mag_on=0. Prescaler keeps running; after DONE_SECS ticks -> IDLE, entry=0000. key_valid, clear, stop or start -> IDLE early; the key digit is discarded.
- count_en is never high outside LOAD and the COOK tick cycle. loadn is low only in LOAD.
- Unused state encodings -> IDLE on the next clock.

Optional Feature:
QUICK_START_EN: defined -> start in IDLE with door_closed loads entry=0030 and goes to LOAD (30 s quick cook). Undefined -> start in IDLE is ignored.

Decomposition:
- Package cook_pkg: state encodings (S_IDLE..S_DONE, 3-bit), BCD_MAX=9, SEC_TENS_MAX=5, QUICK_TIME=16'h0030.
- Sub-module tick_prescaler: parameter TICK_DIV; inputs clr, run; output one-cycle tick; holds its count when run=0.
- cook_ctrl contains the FSM and the entry shift register.

Test Plan (TICK_DIV=4, DONE_SECS=3, behavioural timer-chain model):
- Keys 1,2,5 then start, door closed -> load_data=0125; LOAD shows loadn=0 for 1 cycle; count_en pulses every 4 cycles; 85 ticks later timer_zero -> done=1 for 3 ticks -> IDLE.
- Keys 0,5, start; open door after 2 ticks -> mag_on=0, no count_en while open; close door and start -> first tick arrives after the remaining prescaler count; no loadn pulse.
- Keys 1,7,0 (sec_tens=7), start -> ignored, state=ENTRY; clear -> entry=0000, IDLE.
- Keys 9,9,9,9,1 -> load_data=9991; start with door open -> ignored.
- Clear and door open in the same COOK cycle -> IDLE, entry=0000; timer_zero together with stop -> DONE.
- clrn pulsed low mid-COOK -> all outputs at reset values asynchronously; start in IDLE with QUICK_START_EN -> load_data=0030 then LOAD, without the macro -> no change.
